watch_set_ctrl: RTL and testbench
=================================

Name: watch_set_ctrl

Overview:
Button-driven time-setting controller for the watch datapath. It captures the running time, lets the user edit hour, then minute, then second. It commits all three fields to the datapath in a single one-cycle set pulse. It also drives set-mode-active so the datapath 100 Hz tick stops while editing. It sits between the debounced button block and the watch datapath, and feeds field-select and blink to the FND display mux.

Parameters:
BLINK_HALF_PERIOD, 50_000_000, clk cycles per blink phase (0.5 s at 100 MHz)
TIMEOUT_CYCLES, 1_000_000_000, idle-edit abort time in clk cycles (10 s at 100 MHz; used only with the optional feature)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
i_btn_mode  in  1  one-cycle pulse: enter set mode / cancel edit
i_btn_next  in  1  one-cycle pulse: advance to next field / commit
i_btn_up  in  1  one-cycle pulse: increment current field
i_btn_down  in  1  one-cycle pulse: decrement current field
i_cur_hour  in  5  running hour from datapath
i_cur_min  in  6  running minute from datapath
i_cur_sec  in  6  running second from datapath
o_set_mode_active  out  1  high from LOAD through COMMIT inclusive
o_hour_set  out  1  one-cycle load strobe for hour
o_hour_value  out  5  edit hour register
o_min_set  out  1  one-cycle load strobe for minute
o_min_value  out  6  edit minute register
o_sec_set  out  1  one-cycle load strobe for second
o_sec_value  out  6  edit second register
o_field_sel  out  2  0 none, 1 hour, 2 min, 3 sec
o_blink  out  1  blink phase for the selected field

Behaviour:
- Reset: state IDLE; all outputs 0; edit registers 0; blink counter 0.
- Reset mid-edit: returns to IDLE immediately, no set pulse, and the datapath keeps its time.
- States: IDLE, LOAD, EDIT_HOUR, EDIT_MIN, EDIT_SEC, COMMIT.
- IDLE: i_btn_mode goes to LOAD. Other buttons are ignored.
- LOAD (1 cycle): edit registers capture i_cur_*. Next state EDIT_HOUR.
- EDIT_x: i_btn_next advances HOUR to MIN to SEC to COMMIT. i_btn_mode cancels to IDLE with no commit.
- COMMIT (1 cycle): o_hour_set, o_min_set and o_sec_set are all 1. Next state IDLE.
- Latency: i_btn_mode pulse in IDLE at edge N gives LOAD and o_set_mode_active=1 after edge N+1, and EDIT_HOUR after edge N+2.
- Commit latency: i_btn_next in EDIT_SEC at edge M gives set strobes high for one cycle after edge M+1, and o_set_mode_active=0 after edge M+2.
- Button priority in the same cycle: mode > next > up/down. Up/down are ignored in a cycle where next or mode is accepted.
- Field arithmetic (modular, within field width):
  - up: hour 23 wraps to 0; min/sec 59 wrap to 0.
  - down: hour 0 wraps to 23; min/sec 0 wrap to 59.
  - up and down in the same cycle: the current field is set to 0.
- o_*_value continuously reflect the edit registers. They are meaningful to the datapath only while the set strobe is high.
- Set strobes are never asserted outside COMMIT. o_clear is not driven by this block, because datapath clear overrides set.
- o_field_sel: 1/2/3 in EDIT_HOUR/MIN/SEC; 0 otherwise.
- o_blink:
  - Set to 1 and counter cleared on entry to each EDIT state.
  - Toggles every BLINK_HALF_PERIOD cycles while in an EDIT state.
  - Restarts at 1 on any accepted up/down pulse.
  - 0 outside EDIT states.
- All outputs are registered or decoded from the state register only; there are no combinational paths from inputs to outputs.

Optional Feature:
WATCH_SET_TIMEOUT_EN:
- Defined: a 30-bit inactivity counter runs in EDIT states and clears on any button pulse or state change. Reaching TIMEOUT_CYCLES-1 forces IDLE without commit (same as cancel).
- Undefined: no counter; edit persists indefinitely and TIMEOUT_CYCLES is unused.

Decomposition:
- Package watch_pkg holds:
  - state encoding constants (3-bit);
  - HOUR_MAX=23, MIN_MAX=59, SEC_MAX=59;
  - field-select encodings FS_NONE/FS_HOUR/FS_MIN/FS_SEC.
- One sub-module, wrap_updown (parameters WIDTH, MAX_VAL), computes the next field value from value, up and down.
  - It is purely combinational and instantiated three times.
  - The FSM, edit registers and blink/timeout counters stay in watch_set_ctrl.

Test Plan:
- Enter and commit: cur=12:34:56, mode, next x3. Expect exactly one cycle with all three set strobes high and values 12/34/56, o_set_mode_active high from LOAD to COMMIT, and field_sel sequence 1,2,3,0.
- Wrap: hour=23, up gives 0, down gives 23. In EDIT_MIN, min=0, down gives 59. Commit gives min_value=59.
- Cancel: edit hour 12 to 14, then mode. Expect no set strobes, return to IDLE, and o_set_mode_active=0 on the next cycle.
- Priority: in EDIT_MIN assert next and up together. Expect EDIT_SEC with min unchanged. Up and down together in EDIT_SEC give sec=0.
- Reset mid-edit: assert rst in EDIT_MIN. Expect all outputs 0 immediately and no strobe after release.
- Timeout (WATCH_SET_TIMEOUT_EN, TIMEOUT_CYCLES=100): with no buttons in EDIT_HOUR, expect IDLE after 100 cycles with no strobes. A button at cycle 50 restarts the count.

Source files
------------

// File: rtl/watch_pkg.sv
// Shared types and constants for the watch time-setting controller.
// Holds FSM state encoding, field limits and field-select codes.
package watch_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LOAD   = 3'd1,
      ST_HOUR   = 3'd2,
      ST_MIN    = 3'd3,
      ST_SEC    = 3'd4,
      ST_COMMIT = 3'd5
   } state_t;

   localparam int HOUR_MAX = 23;
   localparam int MIN_MAX  = 59;
   localparam int SEC_MAX  = 59;

   localparam logic [1:0] FS_NONE = 2'd0;
   localparam logic [1:0] FS_HOUR = 2'd1;
   localparam logic [1:0] FS_MIN  = 2'd2;
   localparam logic [1:0] FS_SEC  = 2'd3;

   function automatic logic is_edit(state_t s);
      return (s == ST_HOUR) || (s == ST_MIN) || (s == ST_SEC);
   endfunction

endpackage

// File: rtl/wrap_updown.sv
// Modular up/down step for one time field (0..MAX_VAL).
// Ports: value in, up/down pulses in, nxt = stepped value (up+down gives 0).
module wrap_updown #(
   parameter int WIDTH   = 6,
   parameter int MAX_VAL = 59
) (
   input  logic [WIDTH-1:0] value,
   input  logic             up,
   input  logic             down,
   output logic [WIDTH-1:0] nxt
);

   localparam logic [WIDTH-1:0] MAXV = WIDTH'(MAX_VAL);

   always_comb begin
      nxt = value;
      if (up && down)
         nxt = '0;
      else if (up)
         nxt = (value == MAXV) ? '0 : value + WIDTH'(1);
      else if (down)
         nxt = (value == '0) ? MAXV : value - WIDTH'(1);
   end

endmodule

// File: rtl/watch_set_ctrl.sv
// Button-driven time-setting controller: load, edit h/m/s, commit.
// Ports: clk, rst (async high); i_btn_mode/next/up/down pulses;
//   i_cur_hour/min/sec running time; o_set_mode_active; o_*_set strobes;
//   o_*_value edit registers; o_field_sel; o_blink.
// Optional: define WATCH_SET_TIMEOUT_EN to abort idle edits after
//   TIMEOUT_CYCLES clocks.
module watch_set_ctrl
   import watch_pkg::*;
#(
   parameter int BLINK_HALF_PERIOD = 50_000_000,
   parameter int TIMEOUT_CYCLES    = 1_000_000_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       i_btn_mode,
   input  logic       i_btn_next,
   input  logic       i_btn_up,
   input  logic       i_btn_down,
   input  logic [4:0] i_cur_hour,
   input  logic [5:0] i_cur_min,
   input  logic [5:0] i_cur_sec,
   output logic       o_set_mode_active,
   output logic       o_hour_set,
   output logic [4:0] o_hour_value,
   output logic       o_min_set,
   output logic [5:0] o_min_value,
   output logic       o_sec_set,
   output logic [5:0] o_sec_value,
   output logic [1:0] o_field_sel,
   output logic       o_blink
);

   localparam int BW = $clog2(BLINK_HALF_PERIOD + 1);
   localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF_PERIOD - 1);

   if (BLINK_HALF_PERIOD < 1 || TIMEOUT_CYCLES < 2) begin : g_bad_cfg
      $error("watch_set_ctrl: bad BLINK_HALF_PERIOD/TIMEOUT_CYCLES");
   end

   state_t state, nxt;

   logic [4:0] hour_q, hour_n;
   logic [5:0] min_q, min_n;
   logic [5:0] sec_q, sec_n;
   logic [BW-1:0] bcnt;
   logic blink_q;
   logic ud;
   logic entering;
   logic tmo_hit;

   // Up/down only counts when neither mode nor next wins the cycle.
   assign ud = is_edit(state) && !i_btn_mode && !i_btn_next
               && (i_btn_up || i_btn_down);

`ifdef WATCH_SET_TIMEOUT_EN
   logic [29:0] tcnt;
   logic any_btn;

   assign any_btn = i_btn_mode | i_btn_next | i_btn_up | i_btn_down;
   assign tmo_hit = is_edit(state) && (tcnt == 30'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         tcnt <= '0;
      else if (!is_edit(state) || nxt != state || any_btn)
         tcnt <= '0;
      else
         tcnt <= tcnt + 30'd1;
   end
`else
   assign tmo_hit = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= ST_IDLE;
      else
         state <= nxt;
   end

   always_comb begin
      nxt = state;
      unique case (state)
         ST_IDLE:   if (i_btn_mode) nxt = ST_LOAD;
         ST_LOAD:   nxt = ST_HOUR;
         ST_HOUR: begin
            if (i_btn_mode)      nxt = ST_IDLE;
            else if (i_btn_next) nxt = ST_MIN;
         end
         ST_MIN: begin
            if (i_btn_mode)      nxt = ST_IDLE;
            else if (i_btn_next) nxt = ST_SEC;
         end
         ST_SEC: begin
            if (i_btn_mode)      nxt = ST_IDLE;
            else if (i_btn_next) nxt = ST_COMMIT;
         end
         ST_COMMIT: nxt = ST_IDLE;
         default:   nxt = ST_IDLE;
      endcase
      if (tmo_hit)
         nxt = ST_IDLE;
   end

   always_comb begin
      o_set_mode_active = (state != ST_IDLE);
      o_hour_set        = (state == ST_COMMIT);
      o_min_set         = (state == ST_COMMIT);
      o_sec_set         = (state == ST_COMMIT);
      o_field_sel       = FS_NONE;
      unique case (1'b1)
         state == ST_HOUR: o_field_sel = FS_HOUR;
         state == ST_MIN:  o_field_sel = FS_MIN;
         state == ST_SEC:  o_field_sel = FS_SEC;
         default:          o_field_sel = FS_NONE;
      endcase
   end

   wrap_updown #(.WIDTH(5), .MAX_VAL(HOUR_MAX)) u_hour (
      .value (hour_q),
      .up    (i_btn_up),
      .down  (i_btn_down),
      .nxt   (hour_n)
   );

   wrap_updown #(.WIDTH(6), .MAX_VAL(MIN_MAX)) u_min (
      .value (min_q),
      .up    (i_btn_up),
      .down  (i_btn_down),
      .nxt   (min_n)
   );

   wrap_updown #(.WIDTH(6), .MAX_VAL(SEC_MAX)) u_sec (
      .value (sec_q),
      .up    (i_btn_up),
      .down  (i_btn_down),
      .nxt   (sec_n)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hour_q <= '0;
         min_q  <= '0;
         sec_q  <= '0;
      end else if (state == ST_LOAD) begin
         hour_q <= i_cur_hour;
         min_q  <= i_cur_min;
         sec_q  <= i_cur_sec;
      end else if (ud && !tmo_hit) begin
         if (state == ST_HOUR) hour_q <= hour_n;
         if (state == ST_MIN)  min_q  <= min_n;
         if (state == ST_SEC)  sec_q  <= sec_n;
      end
   end

   assign entering = is_edit(nxt) && (nxt != state);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         blink_q <= 1'b0;
         bcnt    <= '0;
      end else if (!is_edit(nxt)) begin
         blink_q <= 1'b0;
         bcnt    <= '0;
      end else if (entering || ud) begin
         blink_q <= 1'b1;
         bcnt    <= '0;
      end else if (bcnt == BLINK_LAST) begin
         blink_q <= ~blink_q;
         bcnt    <= '0;
      end else begin
         bcnt <= bcnt + BW'(1);
      end
   end

   assign o_hour_value = hour_q;
   assign o_min_value  = min_q;
   assign o_sec_value  = sec_q;
   assign o_blink      = blink_q;

endmodule

// File: tb/tb_watch_set_ctrl.sv
// Self-checking bench for watch_set_ctrl (default build, short blink).
// Table-driven cycle vectors plus reset-at-start and reset-mid-edit.
module tb_watch_set_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       mode = 0, nxt = 0, up = 0, down = 0;
   logic [4:0] ch = 0;
   logic [5:0] cm = 0, cs = 0;
   logic       sma, hset, mset, sset, blink;
   logic [4:0] hv;
   logic [5:0] mv, sv;
   logic [1:0] sel;

   int n_run  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   watch_set_ctrl #(.BLINK_HALF_PERIOD(4), .TIMEOUT_CYCLES(100)) dut (
      .clk               (clk),
      .rst               (rst),
      .i_btn_mode        (mode),
      .i_btn_next        (nxt),
      .i_btn_up          (up),
      .i_btn_down        (down),
      .i_cur_hour        (ch),
      .i_cur_min         (cm),
      .i_cur_sec         (cs),
      .o_set_mode_active (sma),
      .o_hour_set        (hset),
      .o_hour_value      (hv),
      .o_min_set         (mset),
      .o_min_value       (mv),
      .o_sec_set         (sset),
      .o_sec_value       (sv),
      .o_field_sel       (sel),
      .o_blink           (blink)
   );

   typedef struct {
      logic [3:0] btn;   // {mode,next,up,down}
      logic [4:0] ch;
      logic [5:0] cm, cs;
      logic       sma, set;
      logic [1:0] sel;
      logic [4:0] h;
      logic [5:0] m, s;
      logic       blink;
   } vec_t;

   vec_t tv[$];

   function automatic vec_t mk(logic [3:0] b, int c_h, int c_m, int c_s,
                               logic e_sma, logic e_set, int e_sel,
                               int e_h, int e_m, int e_s, logic e_bl);
      vec_t v;
      v.btn = b;
      v.ch = 5'(c_h); v.cm = 6'(c_m); v.cs = 6'(c_s);
      v.sma = e_sma; v.set = e_set; v.sel = 2'(e_sel);
      v.h = 5'(e_h); v.m = 6'(e_m); v.s = 6'(e_s);
      v.blink = e_bl;
      return v;
   endfunction

   task automatic chk(string name, int act, int exp);
      n_run++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic chk_all(string tag, logic e_sma, logic e_set, int e_sel,
                          int e_h, int e_m, int e_s, logic e_bl);
      chk({tag, " sma"},   int'(sma),   int'(e_sma));
      chk({tag, " hset"},  int'(hset),  int'(e_set));
      chk({tag, " mset"},  int'(mset),  int'(e_set));
      chk({tag, " sset"},  int'(sset),  int'(e_set));
      chk({tag, " sel"},   int'(sel),   e_sel);
      chk({tag, " hour"},  int'(hv),    e_h);
      chk({tag, " min"},   int'(mv),    e_m);
      chk({tag, " sec"},   int'(sv),    e_s);
      chk({tag, " blink"}, int'(blink), int'(e_bl));
   endtask

   task automatic press(logic [3:0] b);
      {mode, nxt, up, down} = b;
      @(posedge clk);
      #1;
      {mode, nxt, up, down} = 4'b0;
   endtask

   localparam logic [3:0] NONE = 4'b0000;
   localparam logic [3:0] MODE = 4'b1000;
   localparam logic [3:0] NEXT = 4'b0100;
   localparam logic [3:0] UP   = 4'b0010;
   localparam logic [3:0] DN   = 4'b0001;

   initial begin
      // enter and commit 12:34:56
      tv.push_back(mk(NONE, 12,34,56, 0,0,0, 0,0,0, 0));
      tv.push_back(mk(MODE, 12,34,56, 1,0,0, 0,0,0, 0));
      tv.push_back(mk(NONE, 12,34,56, 1,0,1, 12,34,56, 1));
      tv.push_back(mk(NEXT, 12,34,56, 1,0,2, 12,34,56, 1));
      tv.push_back(mk(NEXT, 12,34,56, 1,0,3, 12,34,56, 1));
      tv.push_back(mk(NEXT, 12,34,56, 1,1,0, 12,34,56, 0));
      tv.push_back(mk(NONE, 12,34,56, 0,0,0, 12,34,56, 0));
      // wraps, blink timing, priority, commit 23:59:00
      tv.push_back(mk(MODE, 23,0,10, 1,0,0, 12,34,56, 0));
      tv.push_back(mk(NONE, 23,0,10, 1,0,1, 23,0,10, 1));
      tv.push_back(mk(UP,   23,0,10, 1,0,1, 0,0,10, 1));
      tv.push_back(mk(DN,   23,0,10, 1,0,1, 23,0,10, 1));
      tv.push_back(mk(NONE, 23,0,10, 1,0,1, 23,0,10, 1));
      tv.push_back(mk(NONE, 23,0,10, 1,0,1, 23,0,10, 1));
      tv.push_back(mk(NONE, 23,0,10, 1,0,1, 23,0,10, 1));
      tv.push_back(mk(NONE, 23,0,10, 1,0,1, 23,0,10, 0));
      tv.push_back(mk(UP,   23,0,10, 1,0,1, 0,0,10, 1));
      tv.push_back(mk(DN,   23,0,10, 1,0,1, 23,0,10, 1));
      tv.push_back(mk(NEXT, 23,0,10, 1,0,2, 23,0,10, 1));
      tv.push_back(mk(DN,   23,0,10, 1,0,2, 23,59,10, 1));
      tv.push_back(mk(NEXT|UP, 23,0,10, 1,0,3, 23,59,10, 1));
      tv.push_back(mk(UP|DN, 23,0,10, 1,0,3, 23,59,0, 1));
      tv.push_back(mk(NEXT, 23,0,10, 1,1,0, 23,59,0, 0));
      tv.push_back(mk(NONE, 23,0,10, 0,0,0, 23,59,0, 0));
      // cancel after editing 12 -> 14
      tv.push_back(mk(MODE, 12,0,0, 1,0,0, 23,59,0, 0));
      tv.push_back(mk(NONE, 12,0,0, 1,0,1, 12,0,0, 1));
      tv.push_back(mk(UP,   12,0,0, 1,0,1, 13,0,0, 1));
      tv.push_back(mk(UP,   12,0,0, 1,0,1, 14,0,0, 1));
      tv.push_back(mk(MODE|NEXT|UP, 12,0,0, 0,0,0, 14,0,0, 0));
      // idle ignores non-mode buttons
      tv.push_back(mk(NEXT, 12,0,0, 0,0,0, 14,0,0, 0));
      tv.push_back(mk(UP|DN, 12,0,0, 0,0,0, 14,0,0, 0));
      tv.push_back(mk(NONE, 12,0,0, 0,0,0, 14,0,0, 0));

      // reset state
      #3;
      chk_all("reset", 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;

      for (int i = 0; i < tv.size(); i++) begin
         {mode, nxt, up, down} = tv[i].btn;
         ch = tv[i].ch; cm = tv[i].cm; cs = tv[i].cs;
         @(posedge clk);
         #1;
         chk_all($sformatf("vec%0d", i), tv[i].sma, tv[i].set,
                 int'(tv[i].sel), int'(tv[i].h), int'(tv[i].m),
                 int'(tv[i].s), tv[i].blink);
      end
      {mode, nxt, up, down} = 4'b0;

      // reset mid-edit in EDIT_MIN
      ch = 5'd7; cm = 6'd8; cs = 6'd9;
      press(MODE);
      press(NONE);
      press(NEXT);
      chk("pre-rst sel", int'(sel), 2);
      #3;
      rst = 1'b1;
      #1;
      chk_all("rst-mid", 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         press(NONE);
         chk($sformatf("post-rst sma%0d", i), int'(sma), 0);
         chk($sformatf("post-rst set%0d", i),
             int'(hset | mset | sset), 0);
      end

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
